// File: rtl/read_fetch.sv
// -----------------------------------------------------------------------------
// read_fetch
//
// Purpose:
//   Read-side fetch engine. Pops 32-bit keys from the key request FIFO, turns
//   each key into a DDR byte address, launches one burst read per key and
//   forwards the returned 256-bit entry to the compute read FIFO. The number
//   of keys fetched but not yet retired (proc_key_release) is capped at
//   MAX_INFLIGHT. Only one DDR fetch is outstanding at any time.
//
// Optional feature (macro FETCH_KEY_CHECK_EN):
//   When defined, the low 32 bits of each returned entry are compared with the
//   requested key. A difference sets bit 256 of the pushed word and bumps the
//   saturating mismatch_count. When undefined, bit 256 is 0, mismatch_count
//   is 0 and no compare logic exists.
//
// Parameters:
//   DDR_BASE             byte base address of the entry table
//   DEFAULT_READ_LENGTH  bytes per fetch
//   MAX_INFLIGHT         max keys fetched and not yet released (1..255)
//
// Ports:
//   clk                        clock, rising edge
//   reset                      synchronous reset, active low
//   key_fifo_q/_empty/_rdreq   key request FIFO (1-cycle read latency)
//   rd_control_*               burst read master control port
//   rd_user_*                  burst read master show-ahead data buffer
//   compute_read_fifo_*        output FIFO, word = {mismatch_flag, entry}
//   log_2_num_workers_in       key right-shift applied before address scaling
//   proc_key_release           one-cycle pulse: one key retired downstream
//   inflight_count             keys currently in flight
//   mismatch_count             entries whose key field differed from the key
// -----------------------------------------------------------------------------
module read_fetch #(
    parameter logic [31:0] DDR_BASE            = 32'd0,
    parameter int unsigned DEFAULT_READ_LENGTH = 32,
    parameter int unsigned MAX_INFLIGHT        = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  key_fifo_q,
    input  logic         key_fifo_empty,
    output logic         key_fifo_rdreq,
    output logic         rd_control_fixed_location,
    output logic [30:0]  rd_control_read_base,
    output logic [30:0]  rd_control_read_length,
    output logic         rd_control_go,
    input  logic         rd_control_done,
    output logic         rd_user_read_buffer,
    input  logic [255:0] rd_user_buffer_data,
    input  logic         rd_user_data_available,
    output logic [256:0] compute_read_fifo_data,
    output logic         compute_read_fifo_wrreq,
    input  logic         compute_read_fifo_full,
    input  logic [31:0]  log_2_num_workers_in,
    input  logic         proc_key_release,
    output logic [7:0]   inflight_count,
    output logic [31:0]  mismatch_count
);

    localparam logic [7:0]  MAX_INFLIGHT_L = 8'(MAX_INFLIGHT);
    localparam logic [30:0] READ_LENGTH_L  = 31'(DEFAULT_READ_LENGTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_KEY,
        S_LATCH,
        S_ISSUE,
        S_WAIT_DATA,
        S_PUSH,
        S_WAIT_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    key_q, key_d;
    logic           rdreq_q, rdreq_d;
    logic [30:0]    base_q, base_d;
    logic [30:0]    length_q, length_d;
    logic           go_q, go_d;
    logic           rdbuf_q, rdbuf_d;
    logic [256:0]   data_q, data_d;
    logic           wrreq_q, wrreq_d;
    logic [7:0]     inflight_q, inflight_d;

    // Only the bits that survive the 31-bit address truncation are kept:
    // (key >> n) << 5 contributes key bits [25:0] of the shifted value.
    logic [25:0]    shifted_key;
    logic [30:0]    fetch_addr;
    logic           inflight_inc;
    logic           inflight_dec;

    assign shifted_key = 26'(key_q >> log_2_num_workers_in);
    assign fetch_addr  = DDR_BASE[30:0] + {shifted_key, 5'b0};

`ifdef FETCH_KEY_CHECK_EN
    logic [31:0]    mismatch_q, mismatch_d;
    logic           key_mismatch;

    assign key_mismatch = (rd_user_buffer_data[31:0] != key_q);
`endif

    // A pop raises the count in the cycle rdreq is high; a release lowers it.
    // Both together cancel. A release at zero has nothing to retire.
    assign inflight_inc = rdreq_q;
    assign inflight_dec = proc_key_release && (inflight_q != 8'd0);

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        rdreq_d    = 1'b0;
        base_d     = base_q;
        length_d   = length_q;
        go_d       = 1'b0;
        rdbuf_d    = 1'b0;
        data_d     = data_q;
        wrreq_d    = 1'b0;
        inflight_d = inflight_q;
`ifdef FETCH_KEY_CHECK_EN
        mismatch_d = mismatch_q;
`endif

        if (inflight_inc && !inflight_dec) begin
            inflight_d = inflight_q + 8'd1;
        end else if (!inflight_inc && inflight_dec) begin
            inflight_d = inflight_q - 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (!key_fifo_empty && (inflight_q < MAX_INFLIGHT_L)) begin
                    rdreq_d = 1'b1;
                    state_d = S_READ_KEY;
                end
            end
            S_READ_KEY: begin
                // key_fifo_q becomes valid one cycle after the pop
                state_d = S_LATCH;
            end
            S_LATCH: begin
                key_d   = key_fifo_q;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                base_d   = fetch_addr;
                length_d = READ_LENGTH_L;
                go_d     = 1'b1;
                state_d  = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (rd_user_data_available) begin
`ifdef FETCH_KEY_CHECK_EN
                    data_d = {key_mismatch, rd_user_buffer_data};
                    if (key_mismatch && (mismatch_q != 32'hFFFF_FFFF)) begin
                        mismatch_d = mismatch_q + 32'd1;
                    end
`else
                    data_d = {1'b0, rd_user_buffer_data};
`endif
                    rdbuf_d = 1'b1;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                // data_q is held untouched while the output FIFO is full
                if (!compute_read_fifo_full) begin
                    wrreq_d = 1'b1;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (rd_control_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            rdreq_q    <= 1'b0;
            base_q     <= '0;
            length_q   <= '0;
            go_q       <= 1'b0;
            rdbuf_q    <= 1'b0;
            data_q     <= '0;
            wrreq_q    <= 1'b0;
            inflight_q <= '0;
`ifdef FETCH_KEY_CHECK_EN
            mismatch_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            rdreq_q    <= rdreq_d;
            base_q     <= base_d;
            length_q   <= length_d;
            go_q       <= go_d;
            rdbuf_q    <= rdbuf_d;
            data_q     <= data_d;
            wrreq_q    <= wrreq_d;
            inflight_q <= inflight_d;
`ifdef FETCH_KEY_CHECK_EN
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign key_fifo_rdreq            = rdreq_q;
    assign rd_control_fixed_location = 1'b0;
    assign rd_control_read_base      = base_q;
    assign rd_control_read_length    = length_q;
    assign rd_control_go             = go_q;
    assign rd_user_read_buffer       = rdbuf_q;
    assign compute_read_fifo_data    = data_q;
    assign compute_read_fifo_wrreq   = wrreq_q;
    assign inflight_count            = inflight_q;
`ifdef FETCH_KEY_CHECK_EN
    assign mismatch_count            = mismatch_q;
`else
    assign mismatch_count            = 32'd0;
`endif

endmodule

// File: tb/tb_read_fetch.sv
// -----------------------------------------------------------------------------
// tb_read_fetch
//
// Self-checking bench for read_fetch. A single process drives all inputs on
// the falling edge and observes DUT outputs there. Behavioural models: a key
// FIFO (array + indices), a DDR read master (latency countdown, one entry
// buffer), a push scoreboard (expected {flag, entry} per fetched key) and an
// in-flight key counter. Directed scenarios are followed by a random phase.
// Honours FETCH_KEY_CHECK_EN for the expected flag and mismatch count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_read_fetch;

    localparam logic [31:0] DDR_BASE = 32'd0;
    localparam int          MAXI     = 2;
`ifdef FETCH_KEY_CHECK_EN
    localparam bit KEY_CHECK = 1'b1;
`else
    localparam bit KEY_CHECK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  key_fifo_q = '0;
    logic         key_fifo_empty = 1'b1;
    logic         key_fifo_rdreq;
    logic         rd_control_fixed_location;
    logic [30:0]  rd_control_read_base;
    logic [30:0]  rd_control_read_length;
    logic         rd_control_go;
    logic         rd_control_done = 1'b1;
    logic         rd_user_read_buffer;
    logic [255:0] rd_user_buffer_data = '0;
    logic         rd_user_data_available = 1'b0;
    logic [256:0] compute_read_fifo_data;
    logic         compute_read_fifo_wrreq;
    logic         compute_read_fifo_full = 1'b0;
    logic [31:0]  log_2_num_workers_in = '0;
    logic         proc_key_release = 1'b0;
    logic [7:0]   inflight_count;
    logic [31:0]  mismatch_count;

    always #5 clk = ~clk;

    read_fetch #(
        .DDR_BASE(DDR_BASE),
        .DEFAULT_READ_LENGTH(32),
        .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_fifo_q(key_fifo_q),
        .key_fifo_empty(key_fifo_empty),
        .key_fifo_rdreq(key_fifo_rdreq),
        .rd_control_fixed_location(rd_control_fixed_location),
        .rd_control_read_base(rd_control_read_base),
        .rd_control_read_length(rd_control_read_length),
        .rd_control_go(rd_control_go),
        .rd_control_done(rd_control_done),
        .rd_user_read_buffer(rd_user_read_buffer),
        .rd_user_buffer_data(rd_user_buffer_data),
        .rd_user_data_available(rd_user_data_available),
        .compute_read_fifo_data(compute_read_fifo_data),
        .compute_read_fifo_wrreq(compute_read_fifo_wrreq),
        .compute_read_fifo_full(compute_read_fifo_full),
        .log_2_num_workers_in(log_2_num_workers_in),
        .proc_key_release(proc_key_release),
        .inflight_count(inflight_count),
        .mismatch_count(mismatch_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // models and knobs
    logic [31:0]  key_tbl [1024];
    int           wr_idx = 0, rd_idx = 0;
    logic [31:0]  exp_keys [$];
    logic [256:0] exp_push [$];
    logic         pop_pend = 1'b0;
    logic [31:0]  pop_key = '0;
    logic         ddr_busy = 1'b0;
    int           ddr_cnt = 0;
    logic [255:0] ddr_entry = '0;
    int           model_cnt = 0;
    logic [31:0]  model_mm = '0;
    int           n_pop = 0, n_go = 0, n_push = 0, n_rdbuf = 0;
    logic         prev_go = 1'b0;
    logic [30:0]  last_base = '0, last_len = '0;
    logic [256:0] last_push = '0;
    int           full_mode = 0, lat_min = 1, lat_max = 6, corrupt_pct = 0;
    int           rel_pending = 0;
    bit           rel_with_pop = 0, rel_rand = 0, force_en = 0;
    logic [31:0]  force_field = '0;

    task automatic check(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] junk256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_key(input logic [31:0] k);
        key_tbl[wr_idx] = k;
        wr_idx++;
    endtask

    task automatic clear_model();
        exp_keys.delete();
        exp_push.delete();
        rd_idx = wr_idx;
        pop_pend = 1'b0;
        ddr_busy = 1'b0;
        ddr_cnt = 0;
        rd_user_data_available = 1'b0;
        rd_control_done = 1'b1;
        model_cnt = 0;
        model_mm = '0;
        rel_pending = 0;
        rel_with_pop = 0;
        force_en = 0;
        proc_key_release = 1'b0;
        key_fifo_empty = 1'b1;
    endtask

    // One clock of environment: observe DUT outputs, update models, drive inputs.
    task automatic tick();
        logic [31:0]  t, k, field;
        logic [255:0] ent;
        logic [256:0] e;
        logic         flag, rel;
        @(negedge clk);
        if (reset) begin
            check("inflight", inflight_count, 8'(model_cnt));

            if (pop_pend) begin
                key_fifo_q = pop_key;
                pop_pend = 1'b0;
            end else begin
                key_fifo_q = $urandom();
            end
            if (key_fifo_rdreq) begin
                check("rdreq_when_empty", key_fifo_empty, 0);
                if (rd_idx != wr_idx) begin
                    pop_key = key_tbl[rd_idx];
                    rd_idx++;
                    exp_keys.push_back(pop_key);
                    pop_pend = 1'b1;
                end
                n_pop++;
            end

            if (rd_user_read_buffer) begin
                check("rdbuf_when_empty", rd_user_data_available, 1);
                n_rdbuf++;
                rd_user_data_available = 1'b0;
                rd_user_buffer_data = junk256();
                ddr_busy = 1'b0;
                rd_control_done = 1'b1;
            end else if (ddr_busy && !rd_user_data_available) begin
                ddr_cnt--;
                if (ddr_cnt <= 0) begin
                    rd_user_data_available = 1'b1;
                    rd_user_buffer_data = ddr_entry;
                end
            end

            if (rd_control_go) begin
                check("go_single", prev_go, 0);
                check("go_outstanding", ddr_busy, 0);
                check("fixed_loc", rd_control_fixed_location, 0);
                check("go_has_key", exp_keys.size() != 0, 1);
                n_go++;
                last_base = rd_control_read_base;
                last_len = rd_control_read_length;
                if (exp_keys.size() != 0) begin
                    k = exp_keys.pop_front();
                    t = DDR_BASE + ((k >> log_2_num_workers_in) << 5);
                    check("go_base", rd_control_read_base, t[30:0]);
                    check("go_len", rd_control_read_length, 31'd32);
                    if (force_en) begin
                        field = force_field;
                        force_en = 0;
                    end else if ($urandom_range(0, 99) < corrupt_pct) begin
                        field = k ^ (32'h1 << $urandom_range(0, 31));
                    end else begin
                        field = k;
                    end
                    ent = junk256();
                    ent[31:0] = field;
                    flag = KEY_CHECK && (field != k);
                    if (flag && model_mm != 32'hFFFF_FFFF) model_mm = model_mm + 1;
                    exp_push.push_back({flag, ent});
                    ddr_entry = ent;
                end
                ddr_busy = 1'b1;
                ddr_cnt = $urandom_range(lat_min, lat_max);
                rd_control_done = 1'b0;
            end

            if (compute_read_fifo_wrreq) begin
                check("wr_when_full", compute_read_fifo_full, 0);
                check("push_expected", exp_push.size() != 0, 1);
                if (exp_push.size() != 0) begin
                    e = exp_push.pop_front();
                    check("push_data", compute_read_fifo_data, e);
                end
                check("mismatch_count", mismatch_count, model_mm);
                last_push = compute_read_fifo_data;
                n_push++;
                $display("[%0t] push %0d flag=%0d key_field=%h inflight=%0d",
                         $time, n_push, compute_read_fifo_data[256],
                         compute_read_fifo_data[31:0], inflight_count);
            end

            rel = 1'b0;
            if (rel_with_pop && key_fifo_rdreq) begin
                rel = 1'b1;
                rel_with_pop = 0;
            end else if (rel_pending > 0) begin
                rel = 1'b1;
                rel_pending--;
            end else if (rel_rand && $urandom_range(0, 7) == 0) begin
                rel = 1'b1;
            end
            proc_key_release = rel;
            model_cnt = model_cnt + int'(key_fifo_rdreq) - int'(rel && model_cnt > 0);
            if (key_fifo_rdreq) check("inflight_cap", model_cnt <= MAXI, 1);
        end else begin
            proc_key_release = 1'b0;
            key_fifo_q = $urandom();
        end

        case (full_mode)
            0:       compute_read_fifo_full = 1'b0;
            1:       compute_read_fifo_full = 1'b1;
            default: compute_read_fifo_full = ($urandom_range(0, 3) == 0);
        endcase
        key_fifo_empty = (rd_idx == wr_idx);
        prev_go = rd_control_go;
    endtask

    function automatic int get_cnt(input int which);
        case (which)
            0:       return n_push;
            1:       return n_go;
            default: return n_rdbuf;
        endcase
    endfunction

    task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
        int i = 0;
        while (get_cnt(which) < target && i < budget) begin
            tick();
            i++;
        end
        check(tag, get_cnt(which) >= target, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {key_fifo_rdreq, rd_control_fixed_location, rd_control_read_base,
                               rd_control_read_length, rd_control_go, rd_user_read_buffer,
                               compute_read_fifo_wrreq, inflight_count, mismatch_count}, '0);
        check({tag, "_data"}, compute_read_fifo_data, '0);
    endtask

    initial begin
        int p0, q0, g0;
        clear_model();
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // T1: single fetch, key 0x15, shift 2 -> base 0xA0
        log_2_num_workers_in = 32'd2;
        p0 = n_push; g0 = n_go;
        push_key(32'h15);
        wait_cnt("t1_timeout", 0, p0 + 1, 200);
        check("t1_base", last_base, 31'h0A0);
        check("t1_len", last_len, 31'd32);
        check("t1_gos", n_go - g0, 1);
        check("t1_flag", last_push[256], 0);
        check("t1_inflight", inflight_count, 1);
        rel_pending = 1;
        repeat (3) tick();
        check("t1_released", inflight_count, 0);

        // T2: output FIFO full for 20 cycles while holding an entry
        full_mode = 1;
        q0 = n_rdbuf;
        p0 = n_push;
        push_key(32'h1234_5678);
        wait_cnt("t2_timeout", 2, q0 + 1, 200);
        repeat (20) tick();
        check("t2_hold", n_push, p0);
        full_mode = 0;
        repeat (6) tick();
        check("t2_one", n_push, p0 + 1);
        rel_pending = 1;
        repeat (3) tick();

        // T3: cap of 2, three keys, then one release frees the third
        q0 = n_pop;
        p0 = n_push;
        for (int i = 0; i < 3; i++) push_key($urandom());
        wait_cnt("t3_timeout", 0, p0 + 2, 400);
        repeat (30) tick();
        check("t3_pops", n_pop - q0, 2);
        check("t3_cap", inflight_count, 2);
        rel_pending = 1;
        wait_cnt("t3_timeout2", 0, p0 + 3, 400);
        check("t3_third", n_pop - q0, 3);
        rel_pending = 2;
        repeat (5) tick();
        check("t3_drained", inflight_count, 0);

        // T4: release coincident with a pop, then release at zero
        p0 = n_push;
        push_key(32'hCAFE_0001);
        wait_cnt("t4_timeout", 0, p0 + 1, 200);
        rel_with_pop = 1;
        push_key(32'hCAFE_0002);
        wait_cnt("t4_timeout2", 0, p0 + 2, 200);
        check("t4_same_cycle", inflight_count, 1);
        rel_pending = 1;
        repeat (3) tick();
        check("t4_to_zero", inflight_count, 0);
        rel_pending = 1;
        repeat (3) tick();
        check("t4_underflow", inflight_count, 0);

        // T5: DDR returns key field 8 for requested key 7
        p0 = n_push;
        force_en = 1;
        force_field = 32'h8;
        push_key(32'h7);
        wait_cnt("t5_timeout", 0, p0 + 1, 200);
        check("t5_flag", last_push[256], KEY_CHECK);
        check("t5_mm", mismatch_count, {31'd0, KEY_CHECK});
        rel_pending = 1;
        repeat (3) tick();

        // T6: reset while waiting for DDR data
        lat_min = 40; lat_max = 60;
        g0 = n_go;
        push_key(32'h0BAD_F00D);
        wait_cnt("t6_timeout", 1, g0 + 1, 200);
        repeat (3) tick();
        reset = 1'b0;
        clear_model();
        tick();
        check_all_zero("t6_reset");
        tick();
        reset = 1'b1;
        lat_min = 1; lat_max = 8;
        p0 = n_push;
        repeat (80) tick();
        check("t6_no_spurious", n_push, p0);

        // Random phase
        rel_rand = 1;
        full_mode = 2;
        corrupt_pct = 25;
        for (int b = 0; b < 4; b++) begin
            log_2_num_workers_in = $urandom_range(0, 6);
            p0 = n_push;
            for (int i = 0; i < 12; i++) push_key($urandom());
            wait_cnt("rand_timeout", 0, p0 + 12, 4000);
            repeat (4) tick();
        end
        rel_rand = 0;
        full_mode = 0;
        rel_pending = 8;
        repeat (20) tick();
        check("end_inflight", inflight_count, 0);
        check("end_scoreboard", exp_push.size(), 0);
        check("end_mm", mismatch_count, model_mm);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
